ycfsm_array: RTL

Clocked, parametrised successor to the single-cell yellow-cell FSM. Provides N independent Morphle Logic match channels sharing one clock. Each channel runs a four-phase dual-rail handshake on `in`/`match`, drives a dual-rail `out`, detects protocol violations, and contributes to a shared completed-evaluation counter. It sits between the self-timed cell fabric and synchronous test/readout logic.

---
 rtl/ycfsm_array.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ycfsm_array.sv
// ycfsm_array: N independent yellow-cell match channels on one clock.
// Each channel runs a four-phase dual-rail handshake on in/match and drives a
// registered dual-rail out. It flags protocol errors in a sticky err bit, and
// every channel adds to one shared counter of completed evaluations.
// Dual-rail encoding: 2'b00 empty, 2'b01 V0, 2'b10 V1, 2'b11 illegal.
// Optional macro YCFSM_SYNC_EN: adds a 2-flop synchroniser on every in/match bit.
module ycfsm_array #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       clear,
  input  logic [2*N-1:0]     in,
  input  logic [2*N-1:0]     match,
  output logic [2*N-1:0]     out,
  output logic [N-1:0]       err,
  output logic [CNT_W-1:0]   count
);

  typedef enum logic [1:0] {StIdle, StHalf, StFire, StDrain} state_e;

  logic [2*N-1:0] in_f, match_f;

`ifdef YCFSM_SYNC_EN
  logic [2*N-1:0] in_s1_q, in_s2_q, match_s1_q, match_s2_q;

  // Two-stage synchroniser on every input rail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_s1_q    <= '0;
      in_s2_q    <= '0;
      match_s1_q <= '0;
      match_s2_q <= '0;
    end else begin
      in_s1_q    <= in;
      in_s2_q    <= in_s1_q;
      match_s1_q <= match;
      match_s2_q <= match_s1_q;
    end
  end

  assign in_f    = in_s2_q;
  assign match_f = match_s2_q;
`else
  assign in_f    = in;
  assign match_f = match;
`endif

  state_e         state_q [N];
  state_e         state_d [N];
  logic [1:0]     gone_q  [N];  // per side {match, in}: went empty while draining
  logic [1:0]     gone_d  [N];
  logic [2*N-1:0] out_q, out_d;
  logic [N-1:0]   err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2*N-1:0] in_p_q, match_p_q;  // previous-edge samples, for valid-to-valid flips

  function automatic logic is_valid(input logic [1:0] v);
    return (v == 2'b01) || (v == 2'b10);
  endfunction

  // Per-channel next state, error detection and shared count accumulation.
  always_comb begin
    logic [1:0] a, b, pa, pb;
    logic       va, vb, ea, eb, ev, fire;
    count_d = count_q;
    out_d   = out_q;
    err_d   = err_q;
    for (int k = 0; k < N; k++) begin
      state_d[k] = state_q[k];
      gone_d[k]  = gone_q[k];
      a    = in_f[2*k +: 2];
      b    = match_f[2*k +: 2];
      pa   = in_p_q[2*k +: 2];
      pb   = match_p_q[2*k +: 2];
      va   = is_valid(a);
      vb   = is_valid(b);
      ea   = (a == 2'b00);
      eb   = (b == 2'b00);
      fire = 1'b0;
      ev   = (a == 2'b11) || (b == 2'b11);
      if (state_q[k] != StIdle) begin
        ev = ev || (va && is_valid(pa) && (a != pa)) || (vb && is_valid(pb) && (b != pb));
      end
      if (state_q[k] == StDrain) begin
        ev = ev || (gone_q[k][0] && !ea) || (gone_q[k][1] && !eb);
      end
      if (clear[k]) begin
        state_d[k]       = StIdle;
        out_d[2*k +: 2]  = 2'b00;
        err_d[k]         = 1'b0;
        gone_d[k]        = 2'b00;
      end else if (ev) begin
        state_d[k]       = StDrain;
        out_d[2*k +: 2]  = 2'b00;
        err_d[k]         = 1'b1;
        gone_d[k]        = 2'b00;
      end else begin
        unique case (state_q[k])
          StIdle: begin
            if (va && vb)      fire = 1'b1;
            else if (va || vb) state_d[k] = StHalf;
          end
          StHalf: begin
            if (va && vb)      fire = 1'b1;
            else if (ea && eb) state_d[k] = StIdle;
          end
          StFire: begin
            if (ea && eb) begin
              state_d[k]      = StIdle;
              out_d[2*k +: 2] = 2'b00;
            end else if (ea || eb) begin
              state_d[k] = StDrain;
              gone_d[k]  = {eb, ea};
            end
          end
          StDrain: begin
            if (ea && eb) begin
              state_d[k]      = StIdle;
              out_d[2*k +: 2] = 2'b00;
              gone_d[k]       = 2'b00;
            end else begin
              gone_d[k] = gone_q[k] | {eb, ea};
            end
          end
          default: state_d[k] = StIdle;
        endcase
      end
      if (fire) begin
        state_d[k]      = StFire;
        out_d[2*k +: 2] = (a == b) ? 2'b10 : 2'b01;
        count_d         = count_d + CNT_W'(1);
      end
    end
  end

  // State, outputs and previous-sample registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        state_q[k] <= StIdle;
        gone_q[k]  <= 2'b00;
      end
      out_q     <= '0;
      err_q     <= '0;
      count_q   <= '0;
      in_p_q    <= '0;
      match_p_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        state_q[k] <= state_d[k];
        gone_q[k]  <= gone_d[k];
      end
      out_q     <= out_d;
      err_q     <= err_d;
      count_q   <= count_d;
      in_p_q    <= in_f;
      match_p_q <= match_f;
    end
  end

  assign out   = out_q;
  assign err   = err_q;
  assign count = count_q;

endmodule
